// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter and its helpers.
package rf_arb_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] wd;
    } wb_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr (wrapping) wins.
// Zero latency; no backpressure of its own, the caller decides whether to honour the grant.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        int w_k;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_k   = 0;
        for (int i = 0; i < N; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (!o_any && i_req[IW'(w_k)]) begin
                o_any             = 1'b1;
                o_gnt[IW'(w_k)]   = 1'b1;
                o_idx             = IW'(w_k);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin share of the register-file write port; grant in cycle N writes in N+1, stall/flush/reset withhold ready.
// Optional same-cycle forwarding of the write in flight under RF_WB_BYPASS_EN.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic [NUM_SRC-1:0]            req_valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] req_rd_i,
    input  logic [NUM_SRC*XLEN-1:0]       req_wd_i,
    output logic [NUM_SRC-1:0]            req_ready_o,
    output logic                          regwrite_o,
    output logic [REG_ADDR_W-1:0]         rd_o,
    output logic [XLEN-1:0]               wd_o,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id_o
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [REG_ADDR_W-1:0]         rs1_i,
    input  logic [REG_ADDR_W-1:0]         rs2_i,
    output logic                          fwd_a_hit_o,
    output logic                          fwd_b_hit_o,
    output logic [XLEN-1:0]               fwd_a_o,
    output logic [XLEN-1:0]               fwd_b_o
`endif
);

    localparam int GW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]    w_gnt;
    logic [GW-1:0]         w_idx;
    logic                  w_any;
    logic                  w_block;
    logic                  w_hs;
    logic [REG_ADDR_W-1:0] w_sel_rd;
    logic [XLEN-1:0]       w_sel_wd;
    logic [GW-1:0]         w_ptr_nxt;

    logic                  r_regwrite;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_wd;
    logic [GW-1:0]         r_gid;
    logic [GW-1:0]         r_ptr;

    rr_pick #(
        .N  (NUM_SRC),
        .IW (GW)
    ) u_pick (
        .i_req (req_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Reset is included so no source sees ready while the arbiter is being cleared.
    assign w_block     = stall_i | flush_i | reset_i;
    assign req_ready_o = (w_any && !w_block) ? w_gnt : '0;
    assign w_hs        = |(req_valid_i & req_ready_o);
    assign w_ptr_nxt   = (w_idx == GW'(NUM_SRC - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_sel_rd = '0;
        w_sel_wd = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_gnt[k]) begin
                w_sel_rd = req_rd_i[k*REG_ADDR_W +: REG_ADDR_W];
                w_sel_wd = req_wd_i[k*XLEN +: XLEN];
            end
        end
    end

    // x0 requests complete the handshake and move the pointer but never raise regwrite.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_wd       <= '0;
            r_gid      <= '0;
            r_ptr      <= '0;
        end else begin
            r_regwrite <= w_hs && !flush_i && (w_sel_rd != REG_ADDR_W'(REG_ZERO));
            if (w_hs) begin
                r_rd  <= w_sel_rd;
                r_wd  <= w_sel_wd;
                r_gid <= w_idx;
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign regwrite_o = r_regwrite;
    assign rd_o       = r_rd;
    assign wd_o       = r_wd;
    assign grant_id_o = r_gid;

`ifdef RF_WB_BYPASS_EN
    assign fwd_a_hit_o = r_regwrite && (r_rd == rs1_i) && (rs1_i != REG_ADDR_W'(REG_ZERO));
    assign fwd_b_hit_o = r_regwrite && (r_rd == rs2_i) && (rs2_i != REG_ADDR_W'(REG_ZERO));
    assign fwd_a_o     = fwd_a_hit_o ? r_wd : '0;
    assign fwd_b_o     = fwd_b_hit_o ? r_wd : '0;
`endif

endmodule
